// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with press/release debounce.
// Accepts one key at a time and emits a single set of one-cycle strobes per physical press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       enter,
  output logic       start,
  output logic       set_pin,
  output logic       store,
  output logic       read,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_REL
  } state_t;

  state_t           state;
  logic [3:0]       row_meta;
  logic [3:0]       rs;
  logic [1:0]       col_idx;
  logic [DIV_W-1:0] scan_cnt;
  logic [CNT_W-1:0] deb_cnt;
  logic [3:0]       pattern;
  logic [1:0]       lat_row;
  logic [1:0]       lat_col;
  logic [1:0]       low_row;
  logic [3:0]       next_code;

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk, so they pass two flops before any decision uses them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      rs       <= 4'b1111;
    end else begin
      row_meta <= row_n;
      rs       <= row_meta;
    end
  end

  always_comb begin
    low_row = 2'd3;
    if (!rs[0])      low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
    next_code = decode(lat_row, lat_col);
  end

  // Counters never pass DEBOUNCE_CYC: every state that counts leaves as soon as the limit is hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_n     <= 4'b1110;
      col_idx   <= 2'd0;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      pattern   <= 4'b1111;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      enter     <= 1'b0;
      start     <= 1'b0;
      set_pin   <= 1'b0;
      store     <= 1'b0;
      read      <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      enter     <= 1'b0;
      start     <= 1'b0;
      set_pin   <= 1'b0;
      store     <= 1'b0;
      read      <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt == DIV_LAST) begin
            scan_cnt <= '0;
            if (rs != 4'b1111) begin
              pattern <= rs;
              lat_row <= low_row;
              lat_col <= col_idx;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_n   <= {col_n[2:0], col_n[3]};
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rs == pattern) begin
            deb_cnt <= deb_cnt + 1'b1;
            if (deb_cnt == DEB_LAST) begin
              state     <= EMIT;
              key_code  <= next_code;
              key_valid <= 1'b1;
              enter     <= (next_code <= 4'd9);
              start     <= (next_code == 4'hA);
              set_pin   <= (next_code == 4'hB);
              store     <= (next_code == 4'hC);
              read      <= (next_code == 4'hD);
              key_held  <= 1'b1;
            end
          end else begin
            deb_cnt  <= '0;
            scan_cnt <= '0;
            col_n    <= {col_n[2:0], col_n[3]};
            col_idx  <= col_idx + 2'd1;
            state    <= SCAN;
          end
        end
        EMIT: begin
          deb_cnt <= '0;
          state   <= WAIT_REL;
        end
        WAIT_REL: begin
          if (rs == 4'b1111) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt  <= '0;
              key_held <= 1'b0;
              scan_cnt <= '0;
              col_n    <= {col_n[2:0], col_n[3]};
              col_idx  <= col_idx + 2'd1;
              state    <= SCAN;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
